// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants and types for the two-requester RAM arbiter
package ram_arb_pkg;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 256;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_LSU   = 1'b1
   } req_id_e;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_cmd_t;

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({{(32-ADDR_W){1'b0}}, addr} < 32'(DEPTH));
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant with internal last-winner state
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       transfer_i,
   output logic [1:0] grant_o,
   output req_id_e    grant_id_o
);
   req_id_e rr_last_q, rr_last_d;

   always_comb begin
      grant_id_o = REQ_FETCH;
      if (valid_i == 2'b11)
         grant_id_o = (rr_last_q == REQ_FETCH) ? REQ_LSU : REQ_FETCH;
      else if (valid_i[1])
         grant_id_o = REQ_LSU;

      grant_o = 2'b00;
      if (|valid_i)
         grant_o = (grant_id_o == REQ_LSU) ? 2'b10 : 2'b01;

      rr_last_d = transfer_i ? grant_id_o : rr_last_q;
   end

   // Reset to LSU so the fetch path wins the first contention.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         rr_last_q <= REQ_LSU;
      else
         rr_last_q <= rr_last_d;
   end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sequencer in front of a single-port RAM with
// one-cycle read latency, response routing and out-of-range suppression
module ram_arbiter
   import ram_arb_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic              req0_wr_i,
   input  logic [ADDR_W-1:0] req0_addr_i,
   input  logic [DATA_W-1:0] req0_wdata_i,
   output logic              rsp0_valid_o,
   output logic [DATA_W-1:0] rsp0_rdata_o,
   output logic              rsp0_err_o,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic              req1_wr_i,
   input  logic [ADDR_W-1:0] req1_addr_i,
   input  logic [DATA_W-1:0] req1_wdata_i,
   output logic              rsp1_valid_o,
   output logic [DATA_W-1:0] rsp1_rdata_o,
   output logic              rsp1_err_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic              ram_rd_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);
   logic [1:0]        valid_eff;
   logic [1:0]        grant;
   req_id_e           grant_id;
   logic              transfer;
   req_cmd_t          sel_cmd;
   logic              sel_ok;
   logic              pend_valid_q, pend_valid_d;
   logic              pend_err_q, pend_err_d;
   req_id_e           pend_id_q, pend_id_d;
   logic [DATA_W-1:0] rsp_data;

   // Requests are masked during reset so every output sits at zero.
   assign valid_eff = {req1_valid_i, req0_valid_i} & {2{~reset_i}};
   assign transfer  = |(valid_eff & grant);

   rr_arb2 u_rr_arb2 (
      .clk_i      (clock_i),
      .rst_i      (reset_i),
      .valid_i    (valid_eff),
      .transfer_i (transfer),
      .grant_o    (grant),
      .grant_id_o (grant_id)
   );

   assign req0_ready_o = grant[0];
   assign req1_ready_o = grant[1];

   always_comb begin
      sel_cmd = '0;
      if (grant[0]) begin
         sel_cmd.wr    = req0_wr_i;
         sel_cmd.addr  = req0_addr_i;
         sel_cmd.wdata = req0_wdata_i;
      end else if (grant[1]) begin
         sel_cmd.wr    = req1_wr_i;
         sel_cmd.addr  = req1_addr_i;
         sel_cmd.wdata = req1_wdata_i;
      end
   end

   assign sel_ok      = in_range(sel_cmd.addr);
   assign ram_addr_o  = sel_cmd.addr;
   assign ram_wdata_o = sel_cmd.wdata;
   assign ram_wr_o    = transfer &  sel_cmd.wr & sel_ok;
   assign ram_rd_o    = transfer & ~sel_cmd.wr & sel_ok;

   always_comb begin
      pend_valid_d = transfer & ~sel_cmd.wr;
      pend_id_d    = pend_id_q;
      pend_err_d   = pend_err_q;
      if (pend_valid_d) begin
         pend_id_d  = grant_id;
         pend_err_d = ~sel_ok;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         pend_valid_q <= 1'b0;
         pend_id_q    <= REQ_FETCH;
         pend_err_q   <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
         pend_err_q   <= pend_err_d;
      end
   end

   // RAM data is only looked at for a live in-range read; its idle high-Z never leaks out.
   assign rsp_data = (pend_valid_q && !pend_err_q) ? ram_rdata_i : '0;

   always_comb begin
      rsp0_valid_o = pend_valid_q && (pend_id_q == REQ_FETCH);
      rsp1_valid_o = pend_valid_q && (pend_id_q == REQ_LSU);
      rsp0_err_o   = rsp0_valid_o & pend_err_q;
      rsp1_err_o   = rsp1_valid_o & pend_err_q;
      rsp0_rdata_o = rsp0_valid_o ? rsp_data : '0;
      rsp1_rdata_o = rsp1_valid_o ? rsp_data : '0;
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural RAM
// and a cycle-level reference model of arbitration and read responses
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req0_ready, req0_wr;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              rsp0_valid, rsp0_err;
   logic [DATA_W-1:0] rsp0_rdata;
   logic              req1_valid, req1_ready, req1_wr;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              rsp1_valid, rsp1_err;
   logic [DATA_W-1:0] rsp1_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wr, ram_rd;
   logic [DATA_W-1:0] ram_wdata;
   wire  [DATA_W-1:0] ram_rdata;

   int checks   = 0;
   int failures = 0;
   bit run_cmp  = 1'b0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clock_i      (clk),
      .reset_i      (rst),
      .req0_valid_i (req0_valid),
      .req0_ready_o (req0_ready),
      .req0_wr_i    (req0_wr),
      .req0_addr_i  (req0_addr),
      .req0_wdata_i (req0_wdata),
      .rsp0_valid_o (rsp0_valid),
      .rsp0_rdata_o (rsp0_rdata),
      .rsp0_err_o   (rsp0_err),
      .req1_valid_i (req1_valid),
      .req1_ready_o (req1_ready),
      .req1_wr_i    (req1_wr),
      .req1_addr_i  (req1_addr),
      .req1_wdata_i (req1_wdata),
      .rsp1_valid_o (rsp1_valid),
      .rsp1_rdata_o (rsp1_rdata),
      .rsp1_err_o   (rsp1_err),
      .ram_addr_o   (ram_addr),
      .ram_wr_o     (ram_wr),
      .ram_wdata_o  (ram_wdata),
      .ram_rd_o     (ram_rd),
      .ram_rdata_i  (ram_rdata)
   );

   // Behavioural single-port RAM: registered read, high-Z when not reading.
   logic [DATA_W-1:0] ram_mem [DEPTH];
   logic              ram_rd_q = 1'b0;
   logic [DATA_W-1:0] ram_q;
   always @(posedge clk) begin
      if (ram_wr) ram_mem[ram_addr[7:0]] <= ram_wdata;
      ram_rd_q <= ram_rd;
      ram_q    <= ram_mem[ram_addr[7:0]];
   end
   assign ram_rdata = ram_rd_q ? ram_q : {DATA_W{1'bz}};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image, last winner, and the response owed next cycle.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                m_last   = 1;
   bit                m_pvalid = 1'b0;
   int                m_pid    = 0;
   bit                m_perr   = 1'b0;
   logic [DATA_W-1:0] m_pdata  = '0;

   always @(negedge clk) begin : compare
      bit any, wr, oor;
      int g, a;
      logic [DATA_W-1:0] wd, e0d, e1d;
      if (run_cmp) begin
         if (rst) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_ram_wr", ram_wr, 0);
            check("rst_ram_rd", ram_rd, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            check("rst_rsp0", {rsp0_valid, rsp0_err}, 0);
            check("rst_rsp1", {rsp1_valid, rsp1_err}, 0);
            check("rst_rsp0_rdata", rsp0_rdata, 0);
            check("rst_rsp1_rdata", rsp1_rdata, 0);
            m_last   = 1;
            m_pvalid = 1'b0;
         end else begin
            any = req0_valid || req1_valid;
            if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
            else                          g = req1_valid ? 1 : 0;
            wr  = any && ((g == 1) ? req1_wr : req0_wr);
            a   = !any ? 0 : int'((g == 1) ? req1_addr : req0_addr);
            wd  = !any ? '0 : ((g == 1) ? req1_wdata : req0_wdata);
            oor = (a >= DEPTH);
            check("ready0", req0_ready, any && g == 0);
            check("ready1", req1_ready, any && g == 1);
            check("ram_addr", ram_addr, a);
            check("ram_wdata", ram_wdata, wd);
            check("ram_wr", ram_wr, any && wr && !oor);
            check("ram_rd", ram_rd, any && !wr && !oor);
            e0d = (m_pvalid && m_pid == 0 && !m_perr) ? m_pdata : '0;
            e1d = (m_pvalid && m_pid == 1 && !m_perr) ? m_pdata : '0;
            check("rsp0_valid", rsp0_valid, m_pvalid && m_pid == 0);
            check("rsp1_valid", rsp1_valid, m_pvalid && m_pid == 1);
            check("rsp0_err", rsp0_err, m_pvalid && m_pid == 0 && m_perr);
            check("rsp1_err", rsp1_err, m_pvalid && m_pid == 1 && m_perr);
            check("rsp0_rdata", rsp0_rdata, e0d);
            check("rsp1_rdata", rsp1_rdata, e1d);
            m_pvalid = any && !wr;
            if (any) begin
               m_last = g;
               if (!wr) begin
                  m_pid   = g;
                  m_perr  = oor;
                  m_pdata = oor ? '0 : ref_mem[a];
               end else if (!oor) begin
                  ref_mem[a] = wd;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic set0(input bit v, input bit w, input int a, input logic [31:0] d);
      req0_valid = v; req0_wr = w; req0_addr = ADDR_W'(a); req0_wdata = d;
   endtask

   task automatic set1(input bit v, input bit w, input int a, input logic [31:0] d);
      req1_valid = v; req1_wr = w; req1_addr = ADDR_W'(a); req1_wdata = d;
   endtask

   task automatic idle();
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
   endtask

   logic r0, r1;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = 32'hA5A5_0000 | 32'(i);
         ref_mem[i] = 32'hA5A5_0000 | 32'(i);
      end
      rst = 1'b1;
      idle();
      set0(1, 0, 5, 0);
      run_cmp = 1'b1;
      mid();
      check("lit_reset_ready0", req0_ready, 0);
      check("lit_reset_ram_rd", ram_rd, 0);
      step();
      idle();
      rst = 1'b0;

      // Write then read back the same address on requester 0.
      step();
      set0(1, 1, 0, 32'h2245_0000);
      mid();
      check("lit_wr_ready0", req0_ready, 1);
      check("lit_wr_ram_wr", ram_wr, 1);
      check("lit_wr_ram_addr", ram_addr, 0);
      step();
      set0(1, 0, 0, 0);
      mid();
      check("lit_rd_ram_rd", ram_rd, 1);
      step();
      idle();
      mid();
      check("lit_rd_rsp0_valid", rsp0_valid, 1);
      check("lit_rd_rsp0_rdata", rsp0_rdata, 32'h2245_0000);
      check("lit_rd_rsp0_err", rsp0_err, 0);

      // Contention after reset alternates 0,1,0,1 with back-to-back responses.
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set0(1, 0, 1, 0);
      set1(1, 0, 2, 0);
      for (int k = 0; k < 4; k++) begin
         mid();
         check("lit_rr_ready0", req0_ready, (k % 2 == 0));
         if (k == 1) check("lit_rr_rsp0_rdata", rsp0_rdata, 32'hA5A5_0001);
         if (k == 2) check("lit_rr_rsp1_rdata", rsp1_rdata, 32'hA5A5_0002);
         if (k > 0)  check("lit_rr_rsp_one", rsp0_valid + rsp1_valid, 1);
         step();
      end
      idle();
      mid();
      check("lit_rr_last_rsp1", rsp1_valid, 1);

      // Out-of-range read and write on requester 1.
      step();
      set1(1, 0, 'h100, 0);
      mid();
      check("lit_oor_ram_rd", ram_rd, 0);
      step();
      set1(1, 1, 'h1FF, 32'hDEAD_BEEF);
      mid();
      check("lit_oor_rsp1_valid", rsp1_valid, 1);
      check("lit_oor_rsp1_err", rsp1_err, 1);
      check("lit_oor_rsp1_rdata", rsp1_rdata, 0);
      check("lit_oor_ram_wr", ram_wr, 0);
      step();
      set1(1, 0, 'h0FF, 0);
      step();
      idle();
      mid();
      check("lit_oor_readback", rsp1_rdata, 32'hA5A5_00FF);

      // Idle: RAM floats, responses stay at zero.
      for (int k = 0; k < 3; k++) step();
      mid();
      check("lit_idle_rsp0_rdata", rsp0_rdata, 0);
      check("lit_idle_rsp1_rdata", rsp1_rdata, 0);
      check("lit_idle_ram_rd", ram_rd, 0);

      // Reset between acceptance and response discards the read.
      step();
      set1(1, 0, 1, 0);
      step();
      rst = 1'b1;
      idle();
      mid();
      check("lit_rst_mid_rsp1_valid", rsp1_valid, 0);
      step();
      rst = 1'b0;
      set0(1, 0, 3, 0);
      set1(1, 0, 4, 0);
      mid();
      check("lit_rst_first_grant0", req0_ready, 1);
      step();
      idle();

      // Randomized traffic with the hold-until-ready contract honoured.
      r0 = 1'b1;
      r1 = 1'b1;
      for (int n = 0; n < 500; n++) begin
         step();
         if ($urandom_range(0, 63) == 0) begin
            rst = 1'b1;
            idle();
         end else begin
            if (rst || !req0_valid || r0)
               set0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 15)),
                    $urandom);
            if (rst || !req1_valid || r1)
               set1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 15)),
                    $urandom);
            rst = 1'b0;
         end
         mid();
         r0 = req0_ready;
         r1 = req1_ready;
      end
      step();
      rst = 1'b0;
      idle();
      for (int k = 0; k < 3; k++) step();
      run_cmp = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port 256x32 RAM.
- Requester 0 is the fetch path; requester 1 is the load/store path. Each presents valid/ready requests and receives read data on a response channel.
- The arbiter issues at most one RAM access per cycle, tracks the one-cycle read latency, and routes read data back to the issuing requester.
- It masks the RAM's high-Z idle output and suppresses out-of-range addresses.

Parameters:
- ADDR_W, 9: address width on the requester and RAM sides.
- DATA_W, 32: data width.
- DEPTH, 256: number of implemented RAM words. Addresses >= DEPTH are out of range.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 presents a request.
- req0_ready  out  1  requester 0 request accepted this cycle (grant).
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- rsp0_valid  out  1  read response for requester 0.
- rsp0_rdata  out  DATA_W  read data; 0 when rsp0_valid = 0.
- rsp0_err  out  1  qualifies rsp0_valid: the read address was out of range.
- req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as above, for requester 1.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rd  out  1  RAM read enable.
- ram_rdata  in  DATA_W  RAM read data; registered in the RAM, valid the cycle after ram_rd; high-Z otherwise.

Behaviour:
- Reset (async, immediate):
  - rr_last = 1, so requester 0 wins the first contention.
  - pend_valid = 0, pend_id = 0, pend_err = 0.
  - All outputs are 0: readies, rsp*_valid, rsp*_rdata, rsp*_err, ram_wr, ram_rd, ram_addr, ram_wdata.
- Arbitration (combinational, every cycle):
  - Only one requester valid: it is granted.
  - Both valid: the requester other than rr_last is granted.
  - req{g}_ready = 1 for the granted requester only. A transfer occurs on valid && ready.
  - rr_last updates to g on every transfer and holds when there is no transfer.
- No backpressure on responses: a request is granted in every cycle any request is valid.
- Requesters hold valid, wr, addr and wdata stable until ready. The arbiter does not check this.
- RAM drive (combinational from the granted request):
  - ram_addr = addr and ram_wdata = wdata.
  - In range (addr < DEPTH): ram_wr = wr, ram_rd = ~wr.
  - Out of range: ram_wr = 0 and ram_rd = 0.
  - No grant: ram_wr = ram_rd = 0, ram_addr = 0, ram_wdata = 0. This is required: the RAM's rdata goes high-Z whenever rd = 0.
- Read tracking (registered):
  - On an accepted read: pend_valid <= 1, pend_id <= g, pend_err <= out_of_range.
  - Otherwise: pend_valid <= 0.
- Read response, in the cycle after acceptance, i.e. one-cycle latency, back-to-back capable:
  - rsp{pend_id}_valid = pend_valid.
  - rsp{pend_id}_rdata = pend_err ? 0 : ram_rdata.
  - rsp{pend_id}_err = pend_err.
  - The non-addressed response port reads all zeros.
  - High-Z must never propagate to rsp*_rdata.
- Writes:
  - No response; complete at the acceptance edge.
  - An out-of-range write is silently dropped.
- Ordering: a write accepted in cycle N followed by a read of the same address in N+1 returns the new data, since the RAM commits the write at edge N.
- A response and a new grant in the same cycle are independent; both proceed.
- Reset asserted mid-read: the pending response is discarded, and rsp*_valid never asserts for it.

Decomposition:
- Package ram_arb_pkg:
  - ADDR_W, DATA_W, DEPTH constants.
  - Requester ID type (1 bit) with REQ_FETCH = 0 and REQ_LSU = 1.
  - Request command fields (wr, addr, wdata).
- Sub-module rr_arb2: 2-input round-robin grant.
  - Inputs: valid[1:0], transfer, clock, reset.
  - Outputs: one-hot grant and grant id.
  - Holds rr_last internally.
- ram_arbiter instantiates rr_arb2, the RAM-drive mux, and the pending-read register and response demux.

Test Plan:
- Reset, then req0 write addr 0x000 data 0x2245_0000 -> req0_ready = 1 the same cycle, ram_wr = 1, ram_addr = 0x000. Next cycle req0 read 0x000 -> rsp0_valid = 1 one cycle later with rsp0_rdata = 0x2245_0000, rsp0_err = 0.
- Both requesters hold reads (0x001, 0x002) for 4 cycles after reset -> grants alternate 0,1,0,1. rsp0/rsp1 alternate with matching data, one response per cycle, no gaps.
- Requester 1 reads addr 0x100 -> ram_rd = 0, and the next cycle gives rsp1_valid = 1, rsp1_err = 1, rsp1_rdata = 0. Requester 1 writes 0x1FF -> ram_wr = 0, and RAM contents are unchanged on read-back of 0x0FF.
- Idle cycles with no requests -> ram_rd = ram_wr = 0, and rsp*_rdata = 0 (never X/Z) while the RAM drives high-Z.
- Issue req1 read of 0x001, then assert reset for 1 cycle before the response edge -> rsp1_valid stays 0. After release, the first contention is granted to requester 0.
